krnl_cam_cmd_arbiter: RTL and testbench

KRNL_CAM_CMD_ARBITER -- requirements
Module: krnl_cam_cmd_arbiter

---
 rtl/krnl_cam_pkg.sv | 24 ++
 rtl/krnl_cam_tag_fifo.sv | 47 ++++
 rtl/krnl_cam_cmd_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_krnl_cam_cmd_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/krnl_cam_pkg.sv
// Shared definitions for the CAM command arbiter: command opcodes, header LEN field
// position and the arbiter state type.
package krnl_cam_pkg;

    localparam logic [31:0] OP_IDLE       = 32'hFFFF_FF00;
    localparam logic [31:0] OP_UPDATE_ALL = 32'hFFFF_FF01;
    localparam logic [31:0] OP_UPDATE_ONE = 32'hFFFF_FF02;
    localparam logic [31:0] OP_SEARCH     = 32'hFFFF_FF03;

    localparam int LEN_LSB = 448;
    localparam int LEN_MSB = 479;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_PASS = 1'b1
    } arb_state_e;

    function automatic logic isLegalOp(input logic [31:0] op);
        return (op == OP_IDLE) || (op == OP_UPDATE_ALL) ||
               (op == OP_UPDATE_ONE) || (op == OP_SEARCH);
    endfunction

endpackage

// File: rtl/krnl_cam_tag_fifo.sv
// Synchronous FIFO of {requester id, result length} tags used to route CAM results
// back to the requester whose SEARCH produced them. DEPTH must be a power of two.
module krnl_cam_tag_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doPush;
    logic             doPop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPush  = push_i && (!full_o || pop_i);
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/krnl_cam_cmd_arbiter.sv
// Round-robin packet arbiter merging NUM_REQ command streams onto one CAM port and
// routing SEARCH results back. Optional macro CAM_ARB_OPCODE_CHECK_EN drops illegal headers.
module krnl_cam_cmd_arbiter
    import krnl_cam_pkg::*;
#(
    parameter int  NUM_REQ      = 2,
    parameter int  C_DATA_WIDTH = 512,
    parameter int  TAG_DEPTH    = 8,
    localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic [NUM_REQ*C_DATA_WIDTH-1:0] s_TDATA,
    input  logic [NUM_REQ-1:0]              s_TVALID,
    output logic [NUM_REQ-1:0]              s_TREADY,
    output logic [C_DATA_WIDTH-1:0]         m_TDATA,
    output logic                            m_TVALID,
    input  logic                            m_TREADY,
    input  logic [C_DATA_WIDTH-1:0]         r_TDATA,
    input  logic                            r_TVALID,
    output logic                            r_TREADY,
    output logic [C_DATA_WIDTH-1:0]         rs_TDATA,
    output logic [NUM_REQ-1:0]              rs_TVALID,
    input  logic [NUM_REQ-1:0]              rs_TREADY,
    output logic [GW-1:0]                   grant_id,
    output logic                            busy
`ifdef CAM_ARB_OPCODE_CHECK_EN
    ,output logic                           err_opcode
`endif
);

    arb_state_e             state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          rrPtr_q, rrPtr_d;
    logic                   isHdr_q, isHdr_d;
    logic [LEN_W-1:0]       beatCnt_q, beatCnt_d;
    logic [LEN_W-1:0]       rsCnt_q, rsCnt_d;

    logic [C_DATA_WIDTH-1:0] curData;
    logic                    curValid;
    logic [31:0]             hdrOp;
    logic [LEN_W-1:0]        hdrLen;
    logic                    dropHdr;
    logic                    beatFire;
    logic                    selValid;
    logic [GW-1:0]           selIdx;
    int                      cand;
    logic                    tagPush, tagPop, tagFull, tagEmpty;
    logic [GW+LEN_W-1:0]     tagHead;
    logic [GW-1:0]           headId;
    logic [LEN_W-1:0]        headLen;
    logic                    rsFire;

    assign curData  = s_TDATA[int'(grant_q)*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign curValid = s_TVALID[grant_q];
    assign hdrOp    = curData[31:0];
    assign hdrLen   = curData[LEN_MSB:LEN_LSB];
    assign grant_id = grant_q;
    assign busy     = (state_q == ST_PASS);

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        selValid = 1'b0;
        selIdx   = '0;
        cand     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rrPtr_q) + k) % NUM_REQ;
            if (!selValid && s_TVALID[cand]) begin
                selValid = 1'b1;
                selIdx   = GW'(cand);
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= ST_ARB;
            grant_q   <= '0;
            rrPtr_q   <= '0;
            isHdr_q   <= 1'b0;
            beatCnt_q <= '0;
            rsCnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rrPtr_q   <= rrPtr_d;
            isHdr_q   <= isHdr_d;
            beatCnt_q <= beatCnt_d;
            rsCnt_q   <= rsCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rrPtr_d   = rrPtr_q;
        isHdr_d   = isHdr_q;
        beatCnt_d = beatCnt_q;
        tagPush   = 1'b0;
        case (state_q)
            ST_ARB: begin
                // A full tag FIFO blocks new grants so an admitted packet never stalls.
                if (selValid && !tagFull) begin
                    state_d = ST_PASS;
                    grant_d = selIdx;
                    rrPtr_d = (selIdx == GW'(NUM_REQ - 1)) ? '0 : selIdx + GW'(1);
                    isHdr_d = 1'b1;
                end
            end
            ST_PASS: begin
                if (beatFire) begin
                    if (isHdr_q) begin
                        isHdr_d   = 1'b0;
                        beatCnt_d = dropHdr ? '0 : hdrLen;
                        tagPush   = !dropHdr && (hdrOp == OP_SEARCH) && (hdrLen != '0);
                        if (dropHdr || hdrLen == '0) state_d = ST_ARB;
                    end else begin
                        beatCnt_d = beatCnt_q - 1'b1;
                        if (beatCnt_q == LEN_W'(1)) state_d = ST_ARB;
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_comb begin
        m_TDATA  = curData;
        m_TVALID = 1'b0;
        s_TREADY = '0;
        dropHdr  = 1'b0;
        beatFire = 1'b0;
        if (state_q == ST_PASS) begin
`ifdef CAM_ARB_OPCODE_CHECK_EN
            dropHdr = isHdr_q && !isLegalOp(hdrOp);
`endif
            m_TVALID          = curValid && !dropHdr;
            s_TREADY[grant_q] = dropHdr ? 1'b1 : m_TREADY;
            beatFire          = curValid && (dropHdr || m_TREADY);
        end
    end

`ifdef CAM_ARB_OPCODE_CHECK_EN
    logic errOp_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)                errOp_q <= 1'b0;
        else if (beatFire && dropHdr) errOp_q <= 1'b1;
    end

    assign err_opcode = errOp_q;
`endif

    krnl_cam_tag_fifo #(
        .WIDTH (GW + LEN_W),
        .DEPTH (TAG_DEPTH)
    ) u_tagFifo (
        .clk_i   (ap_clk),
        .rst_ni  (ap_rst_n),
        .push_i  (tagPush),
        .data_i  ({grant_q, hdrLen}),
        .pop_i   (tagPop),
        .head_o  (tagHead),
        .full_o  (tagFull),
        .empty_o (tagEmpty)
    );

    assign headId  = tagHead[GW+LEN_W-1:LEN_W];
    assign headLen = tagHead[LEN_W-1:0];

    // Results go only to the requester at the head of the tag FIFO.
    always_comb begin
        rs_TDATA  = r_TDATA;
        rs_TVALID = '0;
        r_TREADY  = 1'b0;
        if (!tagEmpty) begin
            rs_TVALID[headId] = r_TVALID;
            r_TREADY          = rs_TREADY[headId];
        end
        rsFire  = !tagEmpty && r_TVALID && r_TREADY;
        tagPop  = rsFire && ((rsCnt_q + LEN_W'(1)) == headLen);
        rsCnt_d = rsCnt_q;
        if (rsFire) rsCnt_d = tagPop ? '0 : rsCnt_q + LEN_W'(1);
    end

endmodule

// File: tb/tb_krnl_cam_cmd_arbiter.sv
// Directed self-checking bench for krnl_cam_cmd_arbiter (2 requesters, 512-bit beats,
// 8-deep tag FIFO); the opcode-drop scenario runs only with CAM_ARB_OPCODE_CHECK_EN.
module tb_krnl_cam_cmd_arbiter;

    localparam int NR = 2;
    localparam int DW = 512;
    localparam int TD = 8;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n;
    logic [NR*DW-1:0] s_TDATA;
    logic [NR-1:0]    s_TVALID;
    logic [NR-1:0]    s_TREADY;
    logic [DW-1:0]    m_TDATA;
    logic             m_TVALID;
    logic             m_TREADY;
    logic [DW-1:0]    r_TDATA;
    logic             r_TVALID;
    logic             r_TREADY;
    logic [DW-1:0]    rs_TDATA;
    logic [NR-1:0]    rs_TVALID;
    logic [NR-1:0]    rs_TREADY;
    logic [0:0]       grant_id;
    logic             busy;
`ifdef CAM_ARB_OPCODE_CHECK_EN
    logic             err_opcode;
`endif

    int total = 0;
    int bad   = 0;

    always #5 ap_clk = ~ap_clk;

    krnl_cam_cmd_arbiter #(
        .NUM_REQ      (NR),
        .C_DATA_WIDTH (DW),
        .TAG_DEPTH    (TD)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .s_TDATA   (s_TDATA),
        .s_TVALID  (s_TVALID),
        .s_TREADY  (s_TREADY),
        .m_TDATA   (m_TDATA),
        .m_TVALID  (m_TVALID),
        .m_TREADY  (m_TREADY),
        .r_TDATA   (r_TDATA),
        .r_TVALID  (r_TVALID),
        .r_TREADY  (r_TREADY),
        .rs_TDATA  (rs_TDATA),
        .rs_TVALID (rs_TVALID),
        .rs_TREADY (rs_TREADY),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef CAM_ARB_OPCODE_CHECK_EN
        ,.err_opcode (err_opcode)
`endif
    );

    // Headers carry the opcode in bits 31:0 and LEN in bits 479:448; a marker byte
    // elsewhere keeps every header distinct.
    function automatic logic [DW-1:0] mkHdr(input logic [31:0] op, input logic [31:0] len,
                                            input logic [7:0] mark);
        logic [DW-1:0] h;
        h            = '0;
        h[31:0]      = op;
        h[479:448]   = len;
        h[63:32]     = {24'h0, mark};
        h[511:504]   = mark;
        return h;
    endfunction

    function automatic logic [DW-1:0] mkBeat(input logic [31:0] v);
        return {16{v}};
    endfunction

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                               input logic [DW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [DW-1:0] data, input logic valid);
        s_TDATA[r*DW +: DW] = data;
        s_TVALID[r]         = valid;
    endtask

    task automatic doReset();
        ap_rst_n = 1'b0;
        #1;
        step();
        ap_rst_n = 1'b1;
    endtask

    // Drives a whole packet from requester r with m_TREADY held high, checking every beat.
    task automatic sendPacket(input int r, input logic [31:0] op, input int len,
                              input logic [7:0] mark);
        logic [DW-1:0] beat;
        int            waitCnt;
        m_TREADY = 1'b1;
        for (int b = 0; b <= len; b++) begin
            beat = (b == 0) ? mkHdr(op, len, mark) : mkBeat({mark, 24'(b)});
            applyStimulus(r, beat, 1'b1);
            #1;
            waitCnt = 0;
            while (!s_TREADY[r] && waitCnt < 20) begin
                step();
                waitCnt++;
            end
            checkOutput("pkt s_TREADY", DW'(s_TREADY[r]), DW'(1));
            checkOutput("pkt m_TDATA", m_TDATA, beat);
            checkOutput("pkt grant_id", DW'(grant_id), DW'(r));
            step();
        end
        applyStimulus(r, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] hdr;
        logic [DW-1:0] beats [5];
        int            idx;
        int            cyc;

        ap_rst_n  = 1'b0;
        s_TDATA   = '0;
        s_TVALID  = '0;
        m_TREADY  = 1'b0;
        r_TDATA   = '0;
        r_TVALID  = 1'b1;
        rs_TREADY = 2'b11;
        #1;
        // Reset state: even with a pending result, nothing routes with an empty tag FIFO.
        checkOutput("rst busy", DW'(busy), DW'(0));
        checkOutput("rst grant_id", DW'(grant_id), DW'(0));
        checkOutput("rst m_TVALID", DW'(m_TVALID), DW'(0));
        checkOutput("rst s_TREADY", DW'(s_TREADY), DW'(0));
        checkOutput("rst r_TREADY", DW'(r_TREADY), DW'(0));
        checkOutput("rst rs_TVALID", DW'(rs_TVALID), DW'(0));
        r_TVALID = 1'b0;
        step();
        ap_rst_n = 1'b1;

        // Single SEARCH LEN=3 from req0, then its three results.
        hdr = mkHdr(32'hFFFF_FF03, 3, 8'h10);
        applyStimulus(0, hdr, 1'b1);
        m_TREADY = 1'b1;
        #1;
        checkOutput("s1 arb busy", DW'(busy), DW'(0));
        checkOutput("s1 arb m_TVALID", DW'(m_TVALID), DW'(0));
        checkOutput("s1 arb s_TREADY", DW'(s_TREADY), DW'(0));
        step();
        checkOutput("s1 hdr busy", DW'(busy), DW'(1));
        checkOutput("s1 hdr grant", DW'(grant_id), DW'(0));
        checkOutput("s1 hdr m_TVALID", DW'(m_TVALID), DW'(1));
        checkOutput("s1 hdr m_TDATA", m_TDATA, hdr);
        checkOutput("s1 hdr s_TREADY", DW'(s_TREADY), DW'(2'b01));
        step();
        for (int b = 1; b <= 3; b++) begin
            applyStimulus(0, mkBeat(32'h1000_0000 + b), 1'b1);
            #1;
            checkOutput("s1 pay m_TVALID", DW'(m_TVALID), DW'(1));
            checkOutput("s1 pay m_TDATA", m_TDATA, mkBeat(32'h1000_0000 + b));
            step();
        end
        applyStimulus(0, '0, 1'b0);
        #1;
        checkOutput("s1 end busy", DW'(busy), DW'(0));
        r_TVALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            r_TDATA = mkBeat(32'h1100_0000 + k);
            #1;
            checkOutput("s1 rs_TVALID", DW'(rs_TVALID), DW'(2'b01));
            checkOutput("s1 r_TREADY", DW'(r_TREADY), DW'(1));
            checkOutput("s1 rs_TDATA", rs_TDATA, mkBeat(32'h1100_0000 + k));
            step();
        end
        #1;
        checkOutput("s1 drained rs_TVALID", DW'(rs_TVALID), DW'(0));
        checkOutput("s1 drained r_TREADY", DW'(r_TREADY), DW'(0));
        r_TVALID = 1'b0;

        // Both requesters valid from reset: req0 first, idle ARB cycle, then req1.
        doReset();
        applyStimulus(0, mkHdr(32'hFFFF_FF02, 1, 8'h20), 1'b1);
        applyStimulus(1, mkHdr(32'hFFFF_FF02, 1, 8'h21), 1'b1);
        #1;
        checkOutput("s2 arb busy", DW'(busy), DW'(0));
        step();
        checkOutput("s2 hdr0 grant", DW'(grant_id), DW'(0));
        checkOutput("s2 hdr0 m_TDATA", m_TDATA, mkHdr(32'hFFFF_FF02, 1, 8'h20));
        checkOutput("s2 hdr0 s_TREADY", DW'(s_TREADY), DW'(2'b01));
        step();
        applyStimulus(0, mkBeat(32'h2000_0001), 1'b1);
        #1;
        checkOutput("s2 pay0 m_TDATA", m_TDATA, mkBeat(32'h2000_0001));
        checkOutput("s2 pay0 s_TREADY", DW'(s_TREADY), DW'(2'b01));
        step();
        applyStimulus(0, '0, 1'b0);
        #1;
        checkOutput("s2 gap busy", DW'(busy), DW'(0));
        checkOutput("s2 gap m_TVALID", DW'(m_TVALID), DW'(0));
        step();
        checkOutput("s2 hdr1 grant", DW'(grant_id), DW'(1));
        checkOutput("s2 hdr1 m_TDATA", m_TDATA, mkHdr(32'hFFFF_FF02, 1, 8'h21));
        checkOutput("s2 hdr1 s_TREADY", DW'(s_TREADY), DW'(2'b10));
        step();
        applyStimulus(1, mkBeat(32'h2100_0001), 1'b1);
        #1;
        checkOutput("s2 pay1 m_TDATA", m_TDATA, mkBeat(32'h2100_0001));
        step();
        applyStimulus(1, '0, 1'b0);
        #1;
        checkOutput("s2 end busy", DW'(busy), DW'(0));

        // 5-beat packet from req0 under toggling m_TREADY; req1 waits with an IDLE LEN=0 header.
        beats[0] = mkHdr(32'hFFFF_FF01, 4, 8'h30);
        for (int i = 1; i < 5; i++) beats[i] = mkBeat(32'h3000_0000 + i);
        applyStimulus(1, mkHdr(32'hFFFF_FF00, 0, 8'h31), 1'b1);
        applyStimulus(0, beats[0], 1'b1);
        m_TREADY = 1'b0;
        #1;
        step();
        idx = 0;
        cyc = 0;
        while (idx < 5 && cyc < 40) begin
            m_TREADY = (cyc % 2 == 1);
            applyStimulus(0, beats[idx], 1'b1);
            #1;
            checkOutput("s3 m_TVALID", DW'(m_TVALID), DW'(1));
            checkOutput("s3 m_TDATA", m_TDATA, beats[idx]);
            checkOutput("s3 s_TREADY", DW'(s_TREADY), DW'({1'b0, m_TREADY}));
            if (m_TREADY) idx++;
            step();
            cyc++;
        end
        checkOutput("s3 beats sent", DW'(idx), DW'(5));
        applyStimulus(0, '0, 1'b0);
        m_TREADY = 1'b1;
        #1;
        checkOutput("s3 end busy", DW'(busy), DW'(0));
        step();
        checkOutput("s3 idle grant", DW'(grant_id), DW'(1));
        checkOutput("s3 idle m_TDATA", m_TDATA, mkHdr(32'hFFFF_FF00, 0, 8'h31));
        checkOutput("s3 idle s_TREADY", DW'(s_TREADY), DW'(2'b10));
        step();
        applyStimulus(1, '0, 1'b0);
        #1;
        checkOutput("s3 len0 end busy", DW'(busy), DW'(0));

        // Fill the tag FIFO with 8 SEARCH LEN=1 tags alternating requesters; ninth is held off.
        for (int k = 0; k < 8; k++) sendPacket(k % 2, 32'hFFFF_FF03, 1, 8'(8'h40 + k));
        applyStimulus(0, mkHdr(32'hFFFF_FF03, 1, 8'h48), 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1;
            checkOutput("s4 full busy", DW'(busy), DW'(0));
            checkOutput("s4 full s_TREADY", DW'(s_TREADY), DW'(0));
            step();
        end
        r_TVALID = 1'b1;
        r_TDATA  = mkBeat(32'h5000_0000);
        #1;
        checkOutput("s4 pop rs_TVALID", DW'(rs_TVALID), DW'(2'b01));
        step();
        r_TVALID = 1'b0;
        #1;
        checkOutput("s4 post-pop arb busy", DW'(busy), DW'(0));
        step();
        checkOutput("s4 ninth busy", DW'(busy), DW'(1));
        sendPacket(0, 32'hFFFF_FF03, 1, 8'h48);
        r_TVALID = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            r_TDATA = mkBeat(32'h5000_0000 + k);
            #1;
            checkOutput("s4 route rs_TVALID", DW'(rs_TVALID), DW'(1 << (k % 2)));
            step();
        end
        r_TVALID = 1'b0;
        #1;
        checkOutput("s4 empty rs_TVALID", DW'(rs_TVALID), DW'(0));
        checkOutput("s4 empty r_TREADY", DW'(r_TREADY), DW'(0));

        // Reset during payload beat 2 of a LEN=4 packet; req0 wins first after release.
        m_TREADY = 1'b1;
        applyStimulus(0, mkHdr(32'hFFFF_FF01, 4, 8'h60), 1'b1);
        #1;
        step();
        step();
        applyStimulus(0, mkBeat(32'h6000_0001), 1'b1);
        step();
        applyStimulus(0, mkBeat(32'h6000_0002), 1'b1);
        applyStimulus(1, mkHdr(32'hFFFF_FF00, 0, 8'h61), 1'b1);
        #1;
        checkOutput("s5 mid m_TDATA", m_TDATA, mkBeat(32'h6000_0002));
        ap_rst_n = 1'b0;
        #1;
        checkOutput("s5 rst m_TVALID", DW'(m_TVALID), DW'(0));
        checkOutput("s5 rst s_TREADY", DW'(s_TREADY), DW'(0));
        checkOutput("s5 rst busy", DW'(busy), DW'(0));
        step();
        ap_rst_n = 1'b1;
        applyStimulus(0, mkHdr(32'hFFFF_FF02, 0, 8'h62), 1'b1);
        #1;
        checkOutput("s5 rel busy", DW'(busy), DW'(0));
        step();
        checkOutput("s5 rel grant", DW'(grant_id), DW'(0));
        checkOutput("s5 rel m_TDATA", m_TDATA, mkHdr(32'hFFFF_FF02, 0, 8'h62));
        step();
        applyStimulus(0, '0, 1'b0);
        #1;
        step();
        checkOutput("s5 req1 grant", DW'(grant_id), DW'(1));
        checkOutput("s5 req1 m_TDATA", m_TDATA, mkHdr(32'hFFFF_FF00, 0, 8'h61));
        step();
        applyStimulus(1, '0, 1'b0);

`ifdef CAM_ARB_OPCODE_CHECK_EN
        // Illegal opcode header is swallowed and flags err_opcode; next legal packet flows.
        applyStimulus(0, mkHdr(32'h1234_5678, 2, 8'h70), 1'b1);
        #1;
        step();
        checkOutput("s6 drop m_TVALID", DW'(m_TVALID), DW'(0));
        checkOutput("s6 drop s_TREADY", DW'(s_TREADY), DW'(2'b01));
        checkOutput("s6 err before", DW'(err_opcode), DW'(0));
        step();
        applyStimulus(0, '0, 1'b0);
        #1;
        checkOutput("s6 err after", DW'(err_opcode), DW'(1));
        checkOutput("s6 back to arb", DW'(busy), DW'(0));
        sendPacket(0, 32'hFFFF_FF02, 1, 8'h71);
        #1;
        checkOutput("s6 err sticky", DW'(err_opcode), DW'(1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
